// File: rtl/kmeans_pkg.sv
// Shared k-means widths and controller state encoding, used by the
// new-means, convergence-check and controller blocks.
package kmeans_pkg;

  localparam int ACCUM_CORD_W = 22;
  localparam int CORD_W       = 13;
  localparam int COUNT_W      = 10;
  localparam int CENT_NUM     = 8;
  localparam int NUM_CORD     = 7;
  localparam int IDX_W        = 3;
  localparam int BITCNT_W     = 5;
  localparam int ACCUM_W      = NUM_CORD * ACCUM_CORD_W;
  localparam int DATA_W       = NUM_CORD * CORD_W;

  localparam logic [CORD_W-1:0] CORD_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cord_divider.sv
// Iterative restoring divider, one quotient bit per step, MSB first.
// quotient shows the post-step value while step is high so the parent can capture the final bit.
module cord_divider
  import kmeans_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic [ACCUM_CORD_W-1:0] dividend,
  input  logic [COUNT_W-1:0]      divisor,
  output logic [ACCUM_CORD_W-1:0] quotient
);

  logic [COUNT_W-1:0]      rem_q;
  logic [COUNT_W-1:0]      dvs_q;
  logic [ACCUM_CORD_W-1:0] quo_q;
  logic [COUNT_W:0]        trial;
  logic [COUNT_W:0]        diff;
  logic                    fits;
  logic [COUNT_W-1:0]      rem_nxt;
  logic [ACCUM_CORD_W-1:0] quo_nxt;

  // Remainder stays below the divisor, so it always fits back in COUNT_W bits.
  always_comb begin
    trial    = {rem_q, quo_q[ACCUM_CORD_W-1]};
    diff     = trial - {1'b0, dvs_q};
    fits     = (trial >= {1'b0, dvs_q});
    rem_nxt  = fits ? diff[COUNT_W-1:0] : trial[COUNT_W-1:0];
    quo_nxt  = {quo_q[ACCUM_CORD_W-2:0], fits};
    quotient = step ? quo_nxt : quo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dvs_q <= divisor;
      quo_q <= dividend;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: rtl/new_means_calc_block.sv
// Recomputes all 8 k-means centroids: per-coordinate accumulator / count,
// saturated to the coordinate width, emitted one centroid per valid strobe.
module new_means_calc_block
  import kmeans_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [IDX_W-1:0]    accum_sel,
  input  logic [ACCUM_W-1:0]  accum_in,
  input  logic [COUNT_W-1:0]  count_in,
  input  logic [DATA_W-1:0]   old_centroid_in,
  output logic [DATA_W-1:0]   new_centroid,
  output logic [IDX_W-1:0]    cent_num,
  output logic                new_centroid_valid,
  output logic                busy,
  output logic                done
);

  state_t                  state_q;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx_q;
  logic [BITCNT_W-1:0]     bit_cnt_q;
  logic                    div_load;
  logic                    div_step;
  logic [ACCUM_CORD_W-1:0] quot [NUM_CORD];
  logic [DATA_W-1:0]       sat_vec;

  function automatic logic [CORD_W-1:0] sat_cord(input logic [ACCUM_CORD_W-1:0] q);
    return (q > ACCUM_CORD_W'(CORD_MAX)) ? CORD_MAX : q[CORD_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = (count_in == '0) ? ST_EMIT : ST_DIV;
      ST_DIV:  if (bit_cnt_q == '0) state_nxt = ST_EMIT;
      ST_EMIT: state_nxt = (idx_q == IDX_W'(CENT_NUM - 1)) ? ST_DONE : ST_LOAD;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy               = (state_q != ST_IDLE);
    new_centroid_valid = (state_q == ST_EMIT);
    done               = (state_q == ST_DONE);
    div_load           = (state_q == ST_LOAD) && (count_in != '0);
    div_step           = (state_q == ST_DIV);
  end

  assign accum_sel = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_LOAD: bit_cnt_q <= BITCNT_W'(ACCUM_CORD_W - 1);
        ST_DIV:  bit_cnt_q <= bit_cnt_q - 1'b1;
        ST_EMIT: idx_q     <= idx_q + 1'b1;
        default: idx_q     <= '0;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CORD; i++) begin : g_div
    cord_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (div_step),
      .dividend (accum_in[i*ACCUM_CORD_W +: ACCUM_CORD_W]),
      .divisor  (count_in),
      .quotient (quot[i])
    );
  end

  always_comb begin
    sat_vec = '0;
    for (int i = 0; i < NUM_CORD; i++) sat_vec[i*CORD_W +: CORD_W] = sat_cord(quot[i]);
  end

  // Results land on entry to EMIT; an empty cluster goes straight from LOAD and keeps its centroid.
  always_ff @(posedge clk) begin
    if (rst) begin
      new_centroid <= '0;
      cent_num     <= '0;
    end else if (state_nxt == ST_EMIT) begin
      cent_num     <= idx_q;
      new_centroid <= (state_q == ST_LOAD) ? old_centroid_in : sat_vec;
    end
  end

endmodule

// File: tb/tb_new_means_calc_block.sv
// Randomized bench for new_means_calc_block against a per-cluster arithmetic
// reference model with an emulated external accumulator/count/centroid mux.
module tb_new_means_calc_block;
  import kmeans_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [IDX_W-1:0]    accum_sel;
  logic [ACCUM_W-1:0]  accum_in;
  logic [COUNT_W-1:0]  count_in;
  logic [DATA_W-1:0]   old_centroid_in;
  logic [DATA_W-1:0]   new_centroid;
  logic [IDX_W-1:0]    cent_num;
  logic                new_centroid_valid;
  logic                busy;
  logic                done;

  logic [ACCUM_W-1:0]  accum_arr [CENT_NUM];
  logic [COUNT_W-1:0]  count_arr [CENT_NUM];
  logic [DATA_W-1:0]   old_arr   [CENT_NUM];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign accum_in        = accum_arr[accum_sel];
  assign count_in        = count_arr[accum_sel];
  assign old_centroid_in = old_arr[accum_sel];

  new_means_calc_block dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .accum_sel          (accum_sel),
    .accum_in           (accum_in),
    .count_in           (count_in),
    .old_centroid_in    (old_centroid_in),
    .new_centroid       (new_centroid),
    .cent_num           (cent_num),
    .new_centroid_valid (new_centroid_valid),
    .busy               (busy),
    .done               (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_cent(input int c);
    logic [DATA_W-1:0] r;
    longint a, q;
    r = '0;
    if (count_arr[c] == 0) return old_arr[c];
    for (int j = 0; j < NUM_CORD; j++) begin
      a = longint'(accum_arr[c][j*ACCUM_CORD_W +: ACCUM_CORD_W]);
      q = a / longint'(count_arr[c]);
      if (q > 8191) q = 8191;
      r[j*CORD_W +: CORD_W] = 13'(q);
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 128'(new_centroid_valid), 128'(0));
    check({tag, "_done"},  128'(done), 128'(0));
    check({tag, "_busy"},  128'(busy), 128'(0));
    check({tag, "_cnum"},  128'(cent_num), 128'(0));
    check({tag, "_cent"},  128'(new_centroid), 128'(0));
    check({tag, "_sel"},   128'(accum_sel), 128'(0));
  endtask

  // Cycle n is the n-th cycle after the edge that samples start (LOAD is cycle 1).
  task automatic run_iter(input int pulse_at, input int abort_at);
    int exp_t [CENT_NUM];
    int t, nvalid, done_t, last_cyc, stray;
    bit done_seen;
    t = 0; nvalid = 0; done_seen = 0; stray = 0;
    for (int c = 0; c < CENT_NUM; c++) begin
      t += (count_arr[c] == 0) ? 2 : 24;
      exp_t[c] = t;
    end
    done_t   = t + 1;
    last_cyc = (abort_at > 0) ? abort_at + 1 : done_t + 6;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      if (abort_at > 0 && cyc == abort_at + 1) begin
        check_reset_outputs("after_rst");
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (new_centroid_valid || done || busy) stray++;
        end
        check("no_activity_after_rst", 128'(stray), 128'(0));
        return;
      end
      if (new_centroid_valid) begin
        if (nvalid < CENT_NUM) begin
          check($sformatf("cent_num_%0d", nvalid), 128'(cent_num), 128'(nvalid));
          check($sformatf("centroid_%0d", nvalid), 128'(new_centroid), 128'(model_cent(nvalid)));
          check($sformatf("valid_cycle_%0d", nvalid), 128'(cyc), 128'(exp_t[nvalid]));
        end else begin
          check("extra_valid", 128'(nvalid), 128'(CENT_NUM - 1));
        end
        nvalid++;
      end
      if (done) begin
        check("done_cycle", 128'(cyc), 128'(done_t));
        done_seen = 1'b1;
      end
      if (cyc == done_t + 1) check("busy_after_done", 128'(busy), 128'(0));
      if (abort_at > 0 && cyc == abort_at) rst = 1'b1;
      start = (cyc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at == 0) begin
      check("valid_count", 128'(nvalid), 128'(CENT_NUM));
      check("done_seen", 128'(done_seen), 128'(1));
    end
  endtask

  task automatic fill_random(input int zero_pct, input bit small_counts);
    for (int c = 0; c < CENT_NUM; c++) begin
      if ($urandom_range(99) < zero_pct) count_arr[c] = '0;
      else if (small_counts) count_arr[c] = 10'($urandom_range(1, 8));
      else count_arr[c] = 10'($urandom_range(1, 1023));
      for (int j = 0; j < NUM_CORD; j++) begin
        accum_arr[c][j*ACCUM_CORD_W +: ACCUM_CORD_W] = 22'($urandom);
        old_arr[c][j*CORD_W +: CORD_W] = 13'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int c = 0; c < CENT_NUM; c++) begin
      accum_arr[c] = '0; count_arr[c] = '0; old_arr[c] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed iteration: exact, truncating, saturating and empty clusters.
    fill_random(0, 1'b0);
    for (int j = 0; j < NUM_CORD; j++) begin
      accum_arr[0][j*ACCUM_CORD_W +: ACCUM_CORD_W] = 22'd1000;
      accum_arr[2][j*ACCUM_CORD_W +: ACCUM_CORD_W] = 22'd4194303;
      accum_arr[3][j*ACCUM_CORD_W +: ACCUM_CORD_W] = 22'd0;
      accum_arr[4][j*ACCUM_CORD_W +: ACCUM_CORD_W] = 22'd4194303;
      old_arr[5][j*CORD_W +: CORD_W] = 13'd777;
    end
    accum_arr[3][ACCUM_CORD_W-1:0] = 22'd1005;
    count_arr[0] = 10'd10;
    count_arr[2] = 10'd1;
    count_arr[3] = 10'd10;
    count_arr[4] = 10'd1023;
    count_arr[5] = 10'd0;
    run_iter(30, 0);

    // Full sweep, every cluster non-empty, start pulsed mid-run.
    fill_random(0, 1'b0);
    run_iter(100, 0);

    // Mixed empty clusters and heavy saturation.
    for (int it = 0; it < 3; it++) begin
      fill_random(35, it[0]);
      run_iter(0, 0);
    end

    // Reset mid-computation, then a clean restart from cluster 0.
    fill_random(0, 1'b0);
    run_iter(0, 50);
    fill_random(0, 1'b1);
    run_iter(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/new_means_calc_block.md
# new_means_calc_block

Computes updated k-means centroids at the end of each iteration. For each of the 8 clusters it divides the per-coordinate accumulator sums by the cluster's point count. Results are presented one centroid at a time, with the centroid index and a one-cycle valid strobe. The block sits directly upstream of convergence_check_block: its new_centroid and cent_num feed that block, and its valid strobe drives convergence_reg_en.

## Interface
- accum_cord_width, 22, width of one accumulated coordinate sum
- cordinate_width, 13, width of one centroid coordinate (unsigned)
- count_width, 10, width of cluster point count
- centroid_num, 8, number of clusters
- accum_width, 7*22, seven accumulated coordinates, coord 1 in LSBs
- dataWidth, 91, seven 13-bit coordinates, coord 1 in LSBs
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  controller request to compute all 8 new centroids
- accum_sel  output  3  cluster index whose accumulator/count/old centroid must be presented (external mux, same cycle)
- accum_in  input  accum_width  accumulator of cluster accum_sel
- count_in  input  count_width  point count of cluster accum_sel
- old_centroid_in  input  dataWidth  current centroid of cluster accum_sel
- new_centroid  output  dataWidth  computed centroid, held until next strobe
- cent_num  output  3  index of new_centroid
- new_centroid_valid  output  1  one-cycle strobe per centroid (-> convergence_reg_en)
- busy  output  1  high from LOAD through DONE
- done  output  1  one-cycle pulse after centroid 7 is emitted

## Operation
- FSM states: IDLE, LOAD, DIV, EMIT, DONE.
- IDLE: idx=0. start=1 -> LOAD. start is ignored in all other states.
- LOAD: accum_sel=idx. Latch accum_in, count_in and old_centroid_in. If count_in==0 -> EMIT with result = old_centroid_in (empty cluster keeps its centroid). Otherwise load seven dividers and go to DIV; bit counter = 21.
- DIV: seven restoring dividers run in parallel, producing one quotient bit per cycle, MSB first. Each divides a 22-bit dividend by the 10-bit divisor count. After bit 0 -> EMIT.
- EMIT: new_centroid and cent_num=idx are updated on entry; new_centroid_valid=1 for this cycle only. If idx==7 -> DONE, else idx+1 -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- Arithmetic: quotient truncates (floor) and has 22 bits. A quotient > 8191 saturates to 8191 per coordinate. The remainder is discarded.
- accum_sel = idx in every state (0 in IDLE).
- rst in any state: FSM -> IDLE, idx=0, dividers cleared, no valid/done emitted. A pending computation is abandoned.

## Timing
- Reset values: new_centroid=0, cent_num=0, new_centroid_valid=0, busy=0, done=0, accum_sel=0.
- start sampled high at edge T: LOAD during cycle T+1, DIV T+2..T+23, EMIT (valid) T+24, next LOAD T+25.
- count==0 cluster: LOAD then EMIT, i.e. 2 cycles per centroid instead of 24.
- All clusters non-empty: last valid at T+192, done at T+193, IDLE at T+194.
- Inputs accum_in/count_in/old_centroid_in are sampled only in LOAD. They may change freely otherwise.
- new_centroid/cent_num are registered and stable from the valid cycle until the next valid. Downstream comparison is combinational on them.

## Structure
- kmeans_pkg: width constants (ACCUM_CORD_W, CORD_W, COUNT_W, CENT_NUM, DATA_W) and the FSM state enum typedef. Shared with convergence_check_block and the controller.
- Sub-module cord_divider: one iterative restoring divider (22/10-bit, load/step inputs, 22-bit quotient), instantiated 7 times. Saturation is applied in the parent.

## Test plan
- Cluster 0: all coords accum=1000, count=10 -> cent_num=0, every coord=100, valid at T+24.
- Cluster 3: coord1=1005, count=10 -> coord1=100 (truncation); other coords accum 0 -> 0.
- Cluster 5: count=0, old centroid coords all 777 -> valid 2 cycles after LOAD, new_centroid=old (all 777).
- Cluster 2: count=1, coord accum=4194303 -> coord saturates to 8191; count=1023, accum=4194303 -> 4100.
- Full sweep, all counts non-zero: exactly 8 valids with cent_num 0..7, done at T+193. start pulsed while busy -> no restart.
- rst asserted at T+50 (mid-cluster 2) -> next cycle all outputs at reset values, no further valid/done. A subsequent start begins again at cluster 0.
